// File: rtl/iter_alu.sv
// iter_alu: EX-stage ALU with registered single-cycle ops and iterative
// mult/div into HI/LO. Define MALU_DIV_EN to build the divider (ops 10/11).
`timescale 1ns/1ps
module iter_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             greater_zero,
  output logic             less_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_result;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_zero;
  logic                 r_gz;
  logic                 r_lz;
  logic [SHW:0]         r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic                 r_neg_q;

  logic [WIDTH-1:0]     w_alu;
  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_is_mul;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_acc;
  logic [2*WIDTH-1:0]   w_prod;

  function automatic logic [SHW:0] f_pop(input logic [WIDTH-1:0] v);
    logic [SHW:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + {{SHW{1'b0}}, v[i]};
    return c;
  endfunction

  // Magnitudes and signs; only the signed ops (odd codes) look at the MSB.
  assign w_neg_a  = op[0] & src_a[WIDTH-1];
  assign w_neg_b  = op[0] & src_b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? ('0 - src_a) : src_a;
  assign w_mag_b  = w_neg_b ? ('0 - src_b) : src_b;
  assign w_is_mul = (op[3:1] == 3'b100);

  // Shift-add step: lower half holds the multiplier, upper half the sum.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_acc[0] ? r_opnd : '0)};
  assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod    = r_neg_q ? ('0 - w_mul_acc) : w_mul_acc;

`ifdef MALU_DIV_EN
  logic                 r_neg_r;
  logic                 r_dz;
  logic                 w_is_div;
  logic [WIDTH:0]       w_div_sh;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_rem;
  logic [2*WIDTH-1:0]   w_div_acc;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  assign w_is_div  = (op[3:1] == 3'b101);
  // Restoring step: upper half is the partial remainder, lower the quotient.
  assign w_div_sh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge  = (w_div_sh >= {1'b0, r_opnd});
  assign w_div_rem = w_div_ge ? (w_div_sh[WIDTH-1:0] - r_opnd)
                              : w_div_sh[WIDTH-1:0];
  assign w_div_acc = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};
  // Divide by zero forces all-ones quotient; remainder falls out as src_a.
  assign w_quo = r_dz ? '1
               : (r_neg_q ? ('0 - w_div_acc[WIDTH-1:0])
                          : w_div_acc[WIDTH-1:0]);
  assign w_rem = r_neg_r ? ('0 - w_div_acc[2*WIDTH-1:WIDTH])
                         : w_div_acc[2*WIDTH-1:WIDTH];
`endif

  // Single-cycle result select.
  always_comb begin
    w_alu = '0;
    case (op)
      4'd0:    w_alu = src_a + src_b;
      4'd1:    w_alu = src_a - src_b;
      4'd2:    w_alu = src_a ^ src_b;
      4'd3:    w_alu = src_a | src_b;
      4'd4:    w_alu = src_b << shamt;
      4'd5:    w_alu = src_b >> shamt;
      4'd6:    w_alu = $signed(src_b) >>> shamt;
      4'd7:    w_alu = {{(WIDTH-1){1'b0}},
                        (f_pop(src_a) == f_pop(~src_b))};
      4'd12:   w_alu = r_hi;
      4'd13:   w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_zero   <= 1'b0;
      r_gz     <= 1'b0;
      r_lz     <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_neg_q  <= 1'b0;
`ifdef MALU_DIV_EN
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_zero <= (src_a == src_b);
            r_gz   <= ~src_a[WIDTH-1] & (|src_a);
            r_lz   <= src_a[WIDTH-1];
            if (w_is_mul) begin
              r_state <= S_MUL;
              r_busy  <= 1'b1;
              r_cnt   <= CNT_INIT;
              r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
              r_opnd  <= w_mag_a;
              r_neg_q <= w_neg_a ^ w_neg_b;
            end
`ifdef MALU_DIV_EN
            else if (w_is_div) begin
              r_state <= S_DIV;
              r_busy  <= 1'b1;
              r_cnt   <= CNT_INIT;
              r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
              r_opnd  <= w_mag_b;
              r_neg_q <= w_neg_a ^ w_neg_b;
              r_neg_r <= w_neg_a;
              r_dz    <= (src_b == '0);
            end
`endif
            else begin
              r_result <= w_alu;
              r_done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt - 1'b1;
          r_acc <= w_mul_acc;
          if (r_cnt == 1) begin
            r_hi    <= w_prod[2*WIDTH-1:WIDTH];
            r_lo    <= w_prod[WIDTH-1:0];
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
`ifdef MALU_DIV_EN
        S_DIV: begin
          r_cnt <= r_cnt - 1'b1;
          r_acc <= w_div_acc;
          if (r_cnt == 1) begin
            r_hi    <= w_rem;
            r_lo    <= w_quo;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign result       = r_result;
  assign hi           = r_hi;
  assign lo           = r_lo;
  assign zero         = r_zero;
  assign greater_zero = r_gz;
  assign less_zero    = r_lz;

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed vector table for single-cycle ops plus
// hand sequences for mult/div latency, ignored start and mid-op reset.
`timescale 1ns/1ps
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        zero;
  logic        greater_zero;
  logic        less_zero;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_res;

  iter_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .shamt(shamt),
    .busy(busy), .done(done), .result(result),
    .hi(hi), .lo(lo), .zero(zero),
    .greater_zero(greater_zero), .less_zero(less_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    start = 1'b1; op = o; src_a = a; src_b = b; shamt = sh;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_multi(input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh,
                           input logic [31:0] el, input string nm);
    int n;
    issue(o, a, b, 5'd0);
    chk({nm, "_busy"}, {31'b0, busy}, 32'd1);
    wait_done(n);
    chk({nm, "_cycles"}, 32'(n), 32'd32);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    chk({nm, "_res"}, result, exp_res);
    chk({nm, "_busy_end"}, {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  task automatic single(input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e,
                        input string nm);
    issue(o, a, b, 5'd0);
    chk({nm, "_done"}, {31'b0, done}, 32'd1);
    chk({nm, "_res"}, result, e);
    exp_res = e;
  endtask

  initial begin
    int n;
    vecs[0]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 3'b001};
    vecs[1]  = '{4'd1,  32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 3'b000};
    vecs[2]  = '{4'd2,  32'h0F0F00FF, 32'h00FF0F0F, 5'd0,  32'h0FF00FF0, 3'b010};
    vecs[3]  = '{4'd3,  32'h12340000, 32'h00005678, 5'd0,  32'h12345678, 3'b010};
    vecs[4]  = '{4'd4,  32'h00000005, 32'h00000001, 5'd31, 32'h80000000, 3'b010};
    vecs[5]  = '{4'd5,  32'h00000000, 32'h80000000, 5'd4,  32'h08000000, 3'b000};
    vecs[6]  = '{4'd6,  32'h80000000, 32'h80000000, 5'd4,  32'hF8000000, 3'b101};
    vecs[7]  = '{4'd7,  32'h0000000F, 32'hFFFFFFF0, 5'd0,  32'h00000001, 3'b010};
    vecs[8]  = '{4'd7,  32'h0000000F, 32'hFFFFFFF8, 5'd0,  32'h00000000, 3'b010};
    vecs[9]  = '{4'd14, 32'h00000007, 32'h00000007, 5'd0,  32'h00000000, 3'b110};
    vecs[10] = '{4'd15, 32'h00000000, 32'h00000000, 5'd0,  32'h00000000, 3'b100};
    vecs[11] = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 3'b010};
    vecs[12] = '{4'd6,  32'h00000001, 32'h7FFFFFFF, 5'd0,  32'h7FFFFFFF, 3'b010};

    reset = 1'b1; start = 1'b0; op = '0;
    src_a = '0; src_b = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_flags", {29'b0, zero, greater_zero, less_zero}, 32'd0);

    // Back-to-back issues: each start lands in the cycle done is high.
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      chk($sformatf("vec%0d_done", i), {31'b0, done}, 32'd1);
      chk($sformatf("vec%0d_res", i), result, vecs[i].res);
      chk($sformatf("vec%0d_flags", i),
          {29'b0, zero, greater_zero, less_zero}, {29'b0, vecs[i].flg});
    end
    exp_res = vecs[12].res;
    @(posedge clk); #1;
    chk("done_drops", {31'b0, done}, 32'd0);

    // MULT -3*5 with an ignored start and operand churn while busy.
    issue(4'd9, 32'hFFFFFFFD, 32'h00000005, 5'd0);
    chk("mult_busy", {31'b0, busy}, 32'd1);
    chk("mult_nodone", {31'b0, done}, 32'd0);
    chk("mult_flags", {29'b0, zero, greater_zero, less_zero}, 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (n == 4) begin
        start = 1'b1; op = 4'd0; src_a = 32'd1; src_b = 32'd1;
      end else begin
        start = 1'b0; src_a = 32'h12345678; src_b = 32'h9;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("mult_cycles", 32'(n), 32'd32);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);
    chk("mult_res_held", result, exp_res);
    chk("mult_flags_held", {29'b0, zero, greater_zero, less_zero}, 32'd1);
    chk("mult_busy_end", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("mult_done_pulse", {31'b0, done}, 32'd0);

    single(4'd12, 32'd0, 32'd0, 32'hFFFFFFFF, "mfhi");
    single(4'd13, 32'd0, 32'd0, 32'hFFFFFFF1, "mflo");

`ifdef MALU_DIV_EN
    run_multi(4'd11, 32'hFFFFFFF9, 32'h00000002,
              32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    run_multi(4'd10, 32'h00000009, 32'h00000000,
              32'h00000009, 32'hFFFFFFFF, "divu_zero");
    run_multi(4'd11, 32'h80000000, 32'hFFFFFFFF,
              32'h00000000, 32'h80000000, "div_min");
`else
    single(4'd11, 32'd10, 32'd2, 32'd0, "nodiv_div");
    chk("nodiv_busy", {31'b0, busy}, 32'd0);
    chk("nodiv_hi", hi, 32'hFFFFFFFF);
    chk("nodiv_lo", lo, 32'hFFFFFFF1);
    single(4'd13, 32'd0, 32'd0, 32'hFFFFFFF1, "mflo2");
    single(4'd10, 32'd10, 32'd2, 32'd0, "nodiv_divu");
    chk("nodivu_hi", hi, 32'hFFFFFFFF);
`endif

    run_multi(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h00000001, "multu_max");

    // Reset partway through MULTU aborts with no HI/LO write.
    issue(4'd8, 32'hFFFFFFFF, 32'h00000002, 5'd0);
    n = 0;
    while (busy === 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_still_busy", {31'b0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    exp_res = 32'd0;

    single(4'd0, 32'd2, 32'd3, 32'd5, "add_after_rst");
    chk("add_after_rst_busy", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
